// File: rtl/fp_div_pkg.sv
// Shared definitions for the FP divide mantissa path.
// Holds the default mantissa/quotient widths, the iteration counter width
// and the controller state type used by mant_div_seq.
package fp_div_pkg;

    localparam int unsigned MANT_W_DEF = 24;
    localparam int unsigned QUOT_W_DEF = 26;
    localparam int unsigned CNT_W_DEF  = $clog2(QUOT_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring divide step (purely combinational).
// Ports:
//   rem_i       partial remainder, MANT_W+1 bits
//   div_i       divisor, MANT_W bits
//   q_o_c       quotient bit: rem_i >= div_i
//   rem_nxt_o_c (q ? rem_i - div_i : rem_i) << 1, truncated to MANT_W+1 bits
module div_step #(
    parameter int unsigned MANT_W = 24
) (
    input  logic [MANT_W:0]   rem_i,
    input  logic [MANT_W-1:0] div_i,
    output logic              q_o_c,
    output logic [MANT_W:0]   rem_nxt_o_c
);

    logic [MANT_W:0] div_ext;
    logic [MANT_W:0] diff;
    logic [MANT_W:0] sel;

    assign div_ext = {1'b0, div_i};
    assign diff    = rem_i - div_ext;

    // Remainder stays below 2*divisor, so dropping the MSB on the shift is lossless.
    always_comb begin
        q_o_c       = (rem_i >= div_ext);
        sel         = q_o_c ? diff : rem_i;
        rem_nxt_o_c = {sel[MANT_W-1:0], 1'b0};
    end

endmodule

// File: rtl/mant_div_seq.sv
// Sequential mantissa divider controller for the FP divide unit.
// Runs one restoring divide step per clock for QUOT_W steps and returns the
// quotient bits plus a sticky bit (final remainder nonzero). A zero divisor
// bypasses the iterations and returns an all-ones quotient with out_dbz set.
// Optional macro MANT_DIV_EARLY_TERM_EN: finish as soon as the remainder
// becomes zero, left-aligning the partial quotient (same result, shorter latency).
// Ports:
//   in_clk, in_rst_n          clock, synchronous active-low reset
//   in_start                  start request, accepted only while out_idle
//   in_dividend, in_divisor   normalized mantissas, sampled on the accept edge
//   in_abort                  flush CALC/DONE back to IDLE
//   in_ready                  consumer takes the result while out_valid
//   out_idle/out_busy/out_valid  state decodes (IDLE/CALC/DONE)
//   out_quotient, out_sticky, out_dbz  result registers
import fp_div_pkg::*;

module mant_div_seq #(
    parameter int unsigned MANT_W = MANT_W_DEF,
    parameter int unsigned QUOT_W = QUOT_W_DEF
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_start,
    input  logic [MANT_W-1:0] in_dividend,
    input  logic [MANT_W-1:0] in_divisor,
    input  logic              in_abort,
    input  logic              in_ready,
    output logic              out_idle,
    output logic              out_busy,
    output logic              out_valid,
    output logic [QUOT_W-1:0] out_quotient,
    output logic              out_sticky,
    output logic              out_dbz
);

    localparam int unsigned CNT_W = $clog2(QUOT_W);
    localparam int unsigned REM_W = MANT_W + 1;

    div_state_e        state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [MANT_W-1:0] dvs_q, dvs_d;
    logic [QUOT_W-1:0] quot_q, quot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [QUOT_W-1:0] res_quot_q, res_quot_d;
    logic              sticky_q, sticky_d;
    logic              dbz_q, dbz_d;
    logic              idle_q, idle_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic              step_q_c;
    logic [REM_W-1:0]  rem_nxt_c;
    logic [QUOT_W-1:0] quot_nxt_c;

    // Single shared divide step.
    div_step #(
        .MANT_W (MANT_W)
    ) u_div_step (
        .rem_i       (rem_q),
        .div_i       (dvs_q),
        .q_o_c       (step_q_c),
        .rem_nxt_o_c (rem_nxt_c)
    );

    assign quot_nxt_c = {quot_q[QUOT_W-2:0], step_q_c};

    // State and datapath registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            res_quot_q <= '0;
            sticky_q   <= 1'b0;
            dbz_q      <= 1'b0;
            idle_q     <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            res_quot_q <= res_quot_d;
            sticky_q   <= sticky_d;
            dbz_q      <= dbz_d;
            idle_q     <= idle_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        res_quot_d = res_quot_q;
        sticky_d   = sticky_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_start) begin
                    if (in_divisor != '0) begin
                        rem_d   = {1'b0, in_dividend};
                        dvs_d   = in_divisor;
                        quot_d  = '0;
                        cnt_d   = CNT_W'(QUOT_W - 1);
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        res_quot_d = '1;
                        sticky_d   = 1'b0;
                        dbz_d      = 1'b1;
                        state_d    = DONE;
                    end
                end
            end

            CALC: begin
                if (in_abort) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = rem_nxt_c;
                    quot_d = quot_nxt_c;
                    if (cnt_q == '0) begin
                        res_quot_d = quot_nxt_c;
                        sticky_d   = (rem_nxt_c != '0);
                        state_d    = DONE;
`ifdef MANT_DIV_EARLY_TERM_EN
                    end else if (rem_nxt_c == '0) begin
                        // Remaining quotient bits are all zero; left-align what we have.
                        res_quot_d = quot_nxt_c << cnt_q;
                        sticky_d   = 1'b0;
                        cnt_d      = '0;
                        state_d    = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            DONE: begin
                if (in_abort || in_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        idle_d  = (state_d == IDLE);
        busy_d  = (state_d == CALC);
        valid_d = (state_d == DONE);
    end

    assign out_idle     = idle_q;
    assign out_busy     = busy_q;
    assign out_valid    = valid_q;
    assign out_quotient = res_quot_q;
    assign out_sticky   = sticky_q;
    assign out_dbz      = dbz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Directed self-checking bench for mant_div_seq (default 24/26 configuration).
module tb_mant_div_seq;

    logic        in_clk;
    logic        in_rst_n;
    logic        in_start;
    logic [23:0] in_dividend;
    logic [23:0] in_divisor;
    logic        in_abort;
    logic        in_ready;
    logic        out_idle;
    logic        out_busy;
    logic        out_valid;
    logic [25:0] out_quotient;
    logic        out_sticky;
    logic        out_dbz;

    int vectors;
    int miscompares;

`ifdef MANT_DIV_EARLY_TERM_EN
    localparam int LAT_1_1  = 1;
    localparam int LAT_15_1 = 2;
`else
    localparam int LAT_1_1  = 26;
    localparam int LAT_15_1 = 26;
`endif
    localparam int LAT_1_15 = 26;

    mant_div_seq u_dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_start     (in_start),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_abort     (in_abort),
        .in_ready     (in_ready),
        .out_idle     (out_idle),
        .out_busy     (out_busy),
        .out_valid    (out_valid),
        .out_quotient (out_quotient),
        .out_sticky   (out_sticky),
        .out_dbz      (out_dbz)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [23:0] a, input logic [23:0] b);
        in_dividend = a;
        in_divisor  = b;
        in_start    = 1'b1;
        tick();
        in_start    = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic consume();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, " idle"},   32'(out_idle),     32'd1);
        chk({pfx, " busy"},   32'(out_busy),     32'd0);
        chk({pfx, " valid"},  32'(out_valid),    32'd0);
        chk({pfx, " quot"},   32'(out_quotient), 32'd0);
        chk({pfx, " sticky"}, 32'(out_sticky),   32'd0);
        chk({pfx, " dbz"},    32'(out_dbz),      32'd0);
    endtask

    initial begin
        int n;
        logic seen_valid;
        vectors     = 0;
        miscompares = 0;
        in_rst_n    = 1'b0;
        in_start    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_abort    = 1'b0;
        in_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("rst");
        in_rst_n = 1'b1;
        tick();

        // 1.0 / 1.0
        start_op(24'h800000, 24'h800000);
        chk("1/1 busy", 32'(out_busy), 32'd1);
        chk("1/1 idle", 32'(out_idle), 32'd0);
        wait_valid(n);
        chk("1/1 latency", 32'(n), 32'(LAT_1_1));
        chk("1/1 quot", 32'(out_quotient), 32'h2000000);
        chk("1/1 sticky", 32'(out_sticky), 32'd0);
        chk("1/1 dbz", 32'(out_dbz), 32'd0);
        consume();
        chk("1/1 idle after ready", 32'(out_idle), 32'd1);
        chk("1/1 valid after ready", 32'(out_valid), 32'd0);
        chk("1/1 quot held in idle", 32'(out_quotient), 32'h2000000);

        // 1.5 / 1.0
        start_op(24'hC00000, 24'h800000);
        wait_valid(n);
        chk("1.5/1 latency", 32'(n), 32'(LAT_15_1));
        chk("1.5/1 quot", 32'(out_quotient), 32'h3000000);
        chk("1.5/1 sticky", 32'(out_sticky), 32'd0);
        consume();

        // 1.0 / 1.5 with input changes and start pulses during CALC
        start_op(24'h800000, 24'hC00000);
        in_dividend = 24'hFFFFFF;
        in_divisor  = 24'h800001;
        in_start    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_start = 1'b0;
        chk("1/1.5 busy after start pulses", 32'(out_busy), 32'd1);
        wait_valid(n);
        chk("1/1.5 latency", 32'(n + 3), 32'(LAT_1_15));
        chk("1/1.5 quot", 32'(out_quotient), 32'h1555555);
        chk("1/1.5 sticky", 32'(out_sticky), 32'd1);
        chk("1/1.5 dbz", 32'(out_dbz), 32'd0);

        // Hold in DONE with in_ready low; start pulses ignored
        for (int i = 0; i < 5; i++) begin
            in_start = (i % 2 == 0);
            tick();
            chk("hold valid", 32'(out_valid), 32'd1);
            chk("hold idle", 32'(out_idle), 32'd0);
            chk("hold quot", 32'(out_quotient), 32'h1555555);
            chk("hold sticky", 32'(out_sticky), 32'd1);
        end
        in_start = 1'b0;
        consume();
        chk("post-hold idle", 32'(out_idle), 32'd1);

        // Divide by zero
        start_op(24'hC00000, 24'h000000);
        chk("dbz valid after accept", 32'(out_valid), 32'd1);
        chk("dbz busy", 32'(out_busy), 32'd0);
        chk("dbz quot", 32'(out_quotient), 32'h3FFFFFF);
        chk("dbz flag", 32'(out_dbz), 32'd1);
        chk("dbz sticky", 32'(out_sticky), 32'd0);
        consume();
        chk("dbz idle after ready", 32'(out_idle), 32'd1);

        // Abort mid-CALC at step 10
        start_op(24'h800000, 24'hC00000);
        seen_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            seen_valid = seen_valid | out_valid;
        end
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk("abort calc idle", 32'(out_idle), 32'd1);
        chk("abort calc busy", 32'(out_busy), 32'd0);
        chk("abort calc valid", 32'(out_valid), 32'd0);
        chk("abort calc no valid seen", 32'(seen_valid), 32'd0);
        chk("abort calc quot held", 32'(out_quotient), 32'h3FFFFFF);
        tick();
        chk("abort stays idle", 32'(out_idle), 32'd1);

        // Abort in DONE
        start_op(24'hC00000, 24'h800000);
        wait_valid(n);
        chk("abort done pre valid", 32'(out_valid), 32'd1);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk("abort done valid", 32'(out_valid), 32'd0);
        chk("abort done idle", 32'(out_idle), 32'd1);
        chk("abort done quot held", 32'(out_quotient), 32'h3000000);

        // Reset mid-CALC, then a clean operation
        start_op(24'h800000, 24'hC00000);
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset busy", 32'(out_busy), 32'd1);
        in_rst_n = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        in_rst_n = 1'b1;
        tick();
        start_op(24'hC00000, 24'h800000);
        wait_valid(n);
        chk("post-rst latency", 32'(n), 32'(LAT_15_1));
        chk("post-rst quot", 32'(out_quotient), 32'h3000000);
        chk("post-rst sticky", 32'(out_sticky), 32'd0);
        chk("post-rst dbz", 32'(out_dbz), 32'd0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
